multicore_system_mem_copier: RTL

MULTICORE_SYSTEM_MEM_COPIER -- requirements
Module: multicore_system_mem_copier

---
 rtl/multicore_system_mem_copier_pkg.sv | 31 +++
 rtl/multicore_system_mem_copier_regs.sv | 118 +++++++++++
 rtl/multicore_system_mem_copier.sv | 140 ++++++++++++++
 3 files changed

// File: rtl/multicore_system_mem_copier_pkg.sv
// Shared definitions for the word-copy engine: control register map,
// CTRL bit positions and the copy FSM state encoding.
package multicore_system_mem_copier_pkg;

    // Control-slave word offsets
    localparam logic [1:0] REG_SRC  = 2'd0;
    localparam logic [1:0] REG_DST  = 2'd1;
    localparam logic [1:0] REG_LEN  = 2'd2;
    localparam logic [1:0] REG_CTRL = 2'd3;

    // CTRL write bits
    localparam int CTRL_GO  = 0;
    localparam int CTRL_IE  = 1;
    localparam int CTRL_CLR = 2;

    // CTRL read bits
    localparam int STAT_BUSY = 0;
    localparam int STAT_DONE = 1;
    localparam int STAT_IE   = 2;

    // Every master access is a full 32-bit word
    localparam logic [3:0] M_BYTEEN_ALL = 4'hF;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_RD_REQ  = 2'd1,
        ST_RD_WAIT = 2'd2,
        ST_WR_REQ  = 2'd3
    } state_t;

endpackage

// File: rtl/multicore_system_mem_copier_regs.sv
// Control register file: SRC/DST/LEN configuration, ie/done status,
// go decode and the registered slave read port.
module multicore_system_mem_copier_regs
    import multicore_system_mem_copier_pkg::*;
#(
    parameter int ADDR_W = 32,
    parameter int LEN_W  = 13
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic [1:0]        s_address,
    input  logic              s_chipselect,
    input  logic              s_read,
    input  logic              s_write,
    input  logic [31:0]       s_writedata,
    output logic [31:0]       s_readdata,
    input  logic              i_busy,
    input  logic              i_complete,
    output logic              o_go,
    output logic              o_irq,
    output logic [ADDR_W-1:0] o_src,
    output logic [ADDR_W-1:0] o_dst,
    output logic [LEN_W-1:0]  o_len
);

    localparam logic [ADDR_W-1:0] ALIGN_MASK = ~ADDR_W'(2'b11);

    logic [ADDR_W-1:0] r_src;
    logic [ADDR_W-1:0] r_dst;
    logic [LEN_W-1:0]  r_len;
    logic              r_ie;
    logic              r_done;
    logic [31:0]       r_rdata;

    logic              w_wr;
    logic              w_rd;
    logic              w_ctrl_wr;
    logic              w_go;
    logic              w_clr;
    logic [ADDR_W-1:0] w_wd_addr;
    logic [31:0]       w_rdata;

    assign w_wr      = s_chipselect & s_write;
    assign w_rd      = s_chipselect & s_read;
    assign w_ctrl_wr = w_wr && (s_address == REG_CTRL);
    assign w_go      = w_ctrl_wr && s_writedata[CTRL_GO] && !i_busy;
    assign w_clr     = w_ctrl_wr && s_writedata[CTRL_CLR];
    assign w_wd_addr = ADDR_W'(s_writedata) & ALIGN_MASK;

    // Read-data mux for the slave port; unused bits read as zero
    always_comb begin
        w_rdata = 32'h0000_0000;
        case (s_address)
            REG_SRC:  w_rdata = 32'(r_src);
            REG_DST:  w_rdata = 32'(r_dst);
            REG_LEN:  w_rdata = 32'(r_len);
            REG_CTRL: begin
                w_rdata[STAT_BUSY] = i_busy;
                w_rdata[STAT_DONE] = r_done;
                w_rdata[STAT_IE]   = r_ie;
            end
            default:  w_rdata = 32'h0000_0000;
        endcase
    end

    // Configuration registers; frozen while a copy is in flight
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_src <= {ADDR_W{1'b0}};
            r_dst <= {ADDR_W{1'b0}};
            r_len <= {LEN_W{1'b0}};
        end else if (w_wr && !i_busy) begin
            case (s_address)
                REG_SRC: r_src <= w_wd_addr;
                REG_DST: r_dst <= w_wd_addr;
                REG_LEN: r_len <= s_writedata[LEN_W-1:0];
                default: ;
            endcase
        end
    end

    // Interrupt enable, writable at any time
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_ie <= 1'b0;
        end else if (w_ctrl_wr) begin
            r_ie <= s_writedata[CTRL_IE];
        end
    end

    // Done flag: completion (or an empty go) wins over a coincident clear
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_done <= 1'b0;
        end else if (i_complete || (w_go && (r_len == {LEN_W{1'b0}}))) begin
            r_done <= 1'b1;
        end else if (w_clr || w_go) begin
            r_done <= 1'b0;
        end
    end

    // Registered slave read data, valid the cycle after the read strobe
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_rdata <= 32'h0000_0000;
        end else if (w_rd) begin
            r_rdata <= w_rdata;
        end
    end

    assign s_readdata = r_rdata;
    assign o_go       = w_go;
    assign o_irq      = r_done & r_ie;
    assign o_src      = r_src;
    assign o_dst      = r_dst;
    assign o_len      = r_len;

endmodule

// File: rtl/multicore_system_mem_copier.sv
// Word-by-word memory copier: one read outstanding at a time, each word
// read from src_ptr then written to dst_ptr, pointers wrapping freely.
module multicore_system_mem_copier
    import multicore_system_mem_copier_pkg::*;
#(
    parameter int ADDR_W = 32,
    parameter int LEN_W  = 13
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic [1:0]        s_address,
    input  logic              s_chipselect,
    input  logic              s_read,
    input  logic              s_write,
    input  logic [31:0]       s_writedata,
    output logic [31:0]       s_readdata,
    output logic              irq,
    output logic [ADDR_W-1:0] m_address,
    output logic              m_read,
    output logic              m_write,
    output logic [31:0]       m_writedata,
    output logic [3:0]        m_byteenable,
    input  logic              m_waitrequest,
    input  logic [31:0]       m_readdata,
    input  logic              m_readdatavalid
);

    localparam logic [ADDR_W-1:0] ADDR_STEP = ADDR_W'(3'd4);
    localparam logic [LEN_W-1:0]  LEN_ONE   = LEN_W'(1'b1);

    state_t            r_state;
    logic [ADDR_W-1:0] r_src_ptr;
    logic [ADDR_W-1:0] r_dst_ptr;
    logic [LEN_W-1:0]  r_count;
    logic [31:0]       r_data;
    logic              r_m_read;
    logic              r_m_write;
    logic [ADDR_W-1:0] r_m_address;

    logic              w_busy;
    logic              w_go;
    logic              w_complete;
    logic [ADDR_W-1:0] w_src;
    logic [ADDR_W-1:0] w_dst;
    logic [LEN_W-1:0]  w_len;

    assign w_busy     = (r_state != ST_IDLE);
    assign w_complete = (r_state == ST_WR_REQ) && !m_waitrequest && (r_count == LEN_ONE);

    multicore_system_mem_copier_regs #(
        .ADDR_W (ADDR_W),
        .LEN_W  (LEN_W)
    ) u_regs (
        .clk          (clk),
        .reset_n      (reset_n),
        .s_address    (s_address),
        .s_chipselect (s_chipselect),
        .s_read       (s_read),
        .s_write      (s_write),
        .s_writedata  (s_writedata),
        .s_readdata   (s_readdata),
        .i_busy       (w_busy),
        .i_complete   (w_complete),
        .o_go         (w_go),
        .o_irq        (irq),
        .o_src        (w_src),
        .o_dst        (w_dst),
        .o_len        (w_len)
    );

    // Copy FSM with registered master strobes, address and captured data
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state     <= ST_IDLE;
            r_src_ptr   <= {ADDR_W{1'b0}};
            r_dst_ptr   <= {ADDR_W{1'b0}};
            r_count     <= {LEN_W{1'b0}};
            r_data      <= 32'h0000_0000;
            r_m_read    <= 1'b0;
            r_m_write   <= 1'b0;
            r_m_address <= {ADDR_W{1'b0}};
        end else begin
            case (r_state)
                ST_IDLE: begin
                    r_m_read  <= 1'b0;
                    r_m_write <= 1'b0;
                    if (w_go && (w_len != {LEN_W{1'b0}})) begin
                        r_state     <= ST_RD_REQ;
                        r_src_ptr   <= w_src;
                        r_dst_ptr   <= w_dst;
                        r_count     <= w_len;
                        r_m_read    <= 1'b1;
                        r_m_address <= w_src;
                    end
                end
                ST_RD_REQ: begin
                    if (!m_waitrequest) begin
                        r_m_read <= 1'b0;
                        r_state  <= ST_RD_WAIT;
                    end
                end
                ST_RD_WAIT: begin
                    if (m_readdatavalid) begin
                        r_data      <= m_readdata;
                        r_m_write   <= 1'b1;
                        r_m_address <= r_dst_ptr;
                        r_state     <= ST_WR_REQ;
                    end
                end
                ST_WR_REQ: begin
                    if (!m_waitrequest) begin
                        r_m_write <= 1'b0;
                        r_src_ptr <= r_src_ptr + ADDR_STEP;
                        r_dst_ptr <= r_dst_ptr + ADDR_STEP;
                        r_count   <= r_count - LEN_ONE;
                        if (r_count == LEN_ONE) begin
                            r_state <= ST_IDLE;
                        end else begin
                            r_state     <= ST_RD_REQ;
                            r_m_read    <= 1'b1;
                            r_m_address <= r_src_ptr + ADDR_STEP;
                        end
                    end
                end
                default: begin
                    r_state   <= ST_IDLE;
                    r_m_read  <= 1'b0;
                    r_m_write <= 1'b0;
                end
            endcase
        end
    end

    assign m_read       = r_m_read;
    assign m_write      = r_m_write;
    assign m_address    = r_m_address;
    assign m_writedata  = r_data;
    assign m_byteenable = M_BYTEEN_ALL;

endmodule
